fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V pipeline. It owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers in-order responses. Each cycle it loads the IF_ID stage register consumed by decode_unit. It honours a decode-side stall and a PC redirect, which flushes fetched-but-unissued work and discards in-flight responses.

---
 rtl/fetch_unit.sv | 159 +++++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit -- RISC-V instruction fetch stage.
// Owns the fetch PC, issues word reads over a valid/ready channel, buffers
// in-order responses and loads the IF_ID stage register each cycle.
// Optional macro FETCH_PREFETCH_BUF_EN: two requests in flight / two-entry
// response buffer (DEPTH=2). Undefined: DEPTH=1.
// if_id_reg layout: [63:32] pc, [31:0] fetched_inst.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [63:0] if_id_reg
);

`ifdef FETCH_PREFETCH_BUF_EN
  localparam int unsigned DEPTH = 2;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic [31:0] fetch_pc;
  logic [1:0]  outstanding;
  logic [1:0]  discard;
  logic [2:0]  in_use;

  // pc tags of non-discarded outstanding requests, oldest at tag_rd
  logic [31:0] tag_mem [2];
  logic        tag_rd, tag_wr;
  logic [1:0]  tag_count;

  // response buffer of {pc, inst} pairs, oldest at buf_rd
  logic [63:0] buf_mem [2];
  logic        buf_rd, buf_wr;
  logic [1:0]  buf_count;

  logic        handshake, rsp_ok, rsp_drop, rsp_take, bypass, buf_push, buf_pop;
  logic [31:0] rsp_pc, redirect_base;
  logic        unused_redirect_lsbs;

  // Ring pointer advance; a single-entry ring always stays at slot 0
  function automatic logic bump(input logic p);
    return (DEPTH > 1) ? ~p : 1'b0;
  endfunction

  assign redirect_base        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign in_use         = {1'b0, outstanding} + {1'b0, buf_count} + {1'b0, discard};
  assign imem_req_valid = reset_n && !redirect_valid && (in_use < 3'(DEPTH));
  assign imem_addr      = fetch_pc;
  assign rsp_pc         = tag_mem[tag_rd];

  // Handshake, response classification and buffer control
  always_comb begin
    handshake = imem_req_valid && imem_req_ready;
    rsp_ok    = imem_rsp_valid && (outstanding != '0);
    rsp_drop  = rsp_ok && (discard != '0);
    rsp_take  = rsp_ok && (discard == '0);
    bypass    = rsp_take && (buf_count == '0) && !id_stall && !redirect_valid;
    buf_push  = rsp_take && !bypass && !redirect_valid;
    buf_pop   = (buf_count != '0) && !id_stall && !redirect_valid;
  end

  // Fetch PC, outstanding-request and discard counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + {1'b0, handshake} - {1'b0, rsp_ok};
      if (redirect_valid) begin
        fetch_pc <= redirect_base;
        // everything still in flight after this cycle belongs to the old path
        discard  <= outstanding - {1'b0, rsp_ok};
      end else begin
        if (handshake) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_drop)  discard  <= discard - 2'd1;
      end
    end
  end

  // Tag ring pointers; flushed on redirect since discarded responses carry no tag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_rd    <= 1'b0;
      tag_wr    <= 1'b0;
      tag_count <= '0;
    end else if (redirect_valid) begin
      tag_rd    <= 1'b0;
      tag_wr    <= 1'b0;
      tag_count <= '0;
    end else begin
      if (handshake) tag_wr <= bump(tag_wr);
      if (rsp_take)  tag_rd <= bump(tag_rd);
      tag_count <= tag_count + {1'b0, handshake} - {1'b0, rsp_take};
    end
  end

  // Tag storage: address of each accepted request
  always_ff @(posedge clk) begin
    if (handshake) tag_mem[tag_wr] <= fetch_pc;
  end

  // Response buffer pointers; push and pop together when full keeps order
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_rd    <= 1'b0;
      buf_wr    <= 1'b0;
      buf_count <= '0;
    end else if (redirect_valid) begin
      buf_rd    <= 1'b0;
      buf_wr    <= 1'b0;
      buf_count <= '0;
    end else begin
      if (buf_push) buf_wr <= bump(buf_wr);
      if (buf_pop)  buf_rd <= bump(buf_rd);
      buf_count <= buf_count + {1'b0, buf_push} - {1'b0, buf_pop};
    end
  end

  // Response buffer storage
  always_ff @(posedge clk) begin
    if (buf_push) buf_mem[buf_wr] <= {rsp_pc, imem_rsp_data};
  end

  // IF_ID register: redirect > stall > buffer head > bypass > bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if_id_reg <= '0;
    end else if (redirect_valid) begin
      if_id_reg <= {redirect_base, NOP_INST};
    end else if (id_stall) begin
      if_id_reg <= if_id_reg;
    end else if (buf_count != '0) begin
      if_id_reg <= buf_mem[buf_rd];
    end else if (bypass) begin
      if_id_reg <= {rsp_pc, imem_rsp_data};
    end else begin
      if_id_reg[31:0] <= NOP_INST;
    end
  end

  // A response with nothing outstanding is a protocol error; it is ignored above
  a_rsp_has_request: assert property (@(posedge clk) disable iff (!reset_n)
    imem_rsp_valid |-> (outstanding != '0));

  a_tag_tracking: assert property (@(posedge clk) disable iff (!reset_n)
    tag_count == (outstanding - discard));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit (either build of
// FETCH_PREFETCH_BUF_EN). Cycle-exact stream/stall table plus directed
// sequences for backpressure, redirects, mid-operation reset and PC wrap.
module tb_fetch_unit;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [63:0] if_id_reg;

  logic        req2;
  logic [31:0] addr2;
  logic [63:0] ifid2;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned delivered = 0;
  logic        saw_zero = 1'b0;
  logic [31:0] exp_fpc = BASE;
  logic [31:0] memq [$];
  logic [63:0] sb [$];

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;
  vec_t tbl [11];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(BASE), .NOP_INST(NOP)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_id_reg(if_id_reg)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_wrap (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(req2), .imem_req_ready(1'b1),
    .imem_addr(addr2), .imem_rsp_valid(1'b0),
    .imem_rsp_data(32'h0), .id_stall(1'b0),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .if_id_reg(ifid2)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hA0 + ((a - BASE) >> 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; reset is asserted asynchronously
  task automatic do_reset();
    reset_n = 1'b0;
    id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'(1'b0));
    chk("rst_addr", 64'(imem_addr), 64'(BASE));
    chk("rst_if_id", if_id_reg, 64'h0);
    chk("rst_wrap_addr", 64'(addr2), 64'(32'hFFFF_FFFC));
    chk("rst_wrap_if_id", ifid2, 64'h0);
    memq.delete();
    sb.delete();
    exp_fpc = BASE;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // One clock: drive at the falling edge, memory answers in order one cycle
  // after acceptance unless held; scoreboard checks the IF_ID register after
  // the rising edge.
  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc,
                      input logic rdy, input logic hold,
                      output logic o_req, output logic [31:0] o_addr, output logic [63:0] o_cur);
    logic        rsp_now;
    logic [63:0] prev, expv;
    id_stall = stall;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_req_ready = rdy;
    rsp_now = !hold && (memq.size() > 0);
    imem_rsp_valid = rsp_now;
    imem_rsp_data = rsp_now ? inst_of(memq[0]) : 32'h0;
    #1;
    o_req = imem_req_valid;
    o_addr = imem_addr;
    chk("fetch_addr", 64'(o_addr), 64'(exp_fpc));
    prev = if_id_reg;
    @(posedge clk);
    if (rsp_now) void'(memq.pop_front());
    if (redir) begin
      sb.delete();
      exp_fpc = {rpc[31:2], 2'b00};
    end else if (o_req && rdy) begin
      memq.push_back(o_addr);
      sb.push_back({exp_fpc, inst_of(exp_fpc)});
      exp_fpc = exp_fpc + 32'd4;
    end
    #1;
    o_cur = if_id_reg;
    if (redir) begin
      chk("redirect_if_id", o_cur, {exp_fpc, NOP});
    end else if (stall) begin
      chk("stall_hold", o_cur, prev);
    end else if (o_cur[31:0] == NOP) begin
      chk("bubble_pc", 64'(o_cur[63:32]), 64'(prev[63:32]));
    end else if (sb.size() == 0) begin
      chk("unexpected_delivery", o_cur, 64'h0);
    end else begin
      expv = sb.pop_front();
      chk("deliver", o_cur, expv);
      delivered++;
      if (o_cur[63:32] == 32'h0) saw_zero = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic        req;
    logic [31:0] addr;
    logic [63:0] cur;
    int unsigned d0;

    // {stall, req_valid, addr (before edge), if_id pc, if_id inst (after edge)}
`ifdef FETCH_PREFETCH_BUF_EN
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 32'h000, NOP};
    tbl[1]  = '{1'b0, 1'b1, 32'h104, 32'h100, 32'hA0};
    tbl[2]  = '{1'b0, 1'b1, 32'h108, 32'h104, 32'hA1};
    tbl[3]  = '{1'b0, 1'b1, 32'h10C, 32'h108, 32'hA2};
    tbl[4]  = '{1'b1, 1'b1, 32'h110, 32'h108, 32'hA2};
    tbl[5]  = '{1'b1, 1'b0, 32'h114, 32'h108, 32'hA2};
    tbl[6]  = '{1'b1, 1'b0, 32'h114, 32'h108, 32'hA2};
    tbl[7]  = '{1'b0, 1'b0, 32'h114, 32'h10C, 32'hA3};
    tbl[8]  = '{1'b0, 1'b1, 32'h114, 32'h110, 32'hA4};
    tbl[9]  = '{1'b0, 1'b1, 32'h118, 32'h114, 32'hA5};
    tbl[10] = '{1'b0, 1'b1, 32'h11C, 32'h118, 32'hA6};
`else
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 32'h000, NOP};
    tbl[1]  = '{1'b0, 1'b0, 32'h104, 32'h100, 32'hA0};
    tbl[2]  = '{1'b0, 1'b1, 32'h104, 32'h100, NOP};
    tbl[3]  = '{1'b0, 1'b0, 32'h108, 32'h104, 32'hA1};
    tbl[4]  = '{1'b1, 1'b1, 32'h108, 32'h104, 32'hA1};
    tbl[5]  = '{1'b1, 1'b0, 32'h10C, 32'h104, 32'hA1};
    tbl[6]  = '{1'b1, 1'b0, 32'h10C, 32'h104, 32'hA1};
    tbl[7]  = '{1'b0, 1'b0, 32'h10C, 32'h108, 32'hA2};
    tbl[8]  = '{1'b0, 1'b1, 32'h10C, 32'h108, NOP};
    tbl[9]  = '{1'b0, 1'b0, 32'h110, 32'h10C, 32'hA3};
    tbl[10] = '{1'b0, 1'b1, 32'h110, 32'h10C, NOP};
`endif

    @(negedge clk);
    do_reset();

    // Stream from reset with a 3-cycle decode stall in the middle
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].stall, 1'b0, 32'h0, 1'b1, 1'b0, req, addr, cur);
      chk($sformatf("tbl%0d_req_valid", i), 64'(req), 64'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), 64'(addr), 64'(tbl[i].addr));
      chk($sformatf("tbl%0d_if_id", i), cur, {tbl[i].pc, tbl[i].inst});
      if (i == 0) chk("wrap_reset_next_addr", 64'(addr2), 64'h0);
    end

    // Backpressure: memory not ready for 4 cycles (also a mid-stream reset)
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, req, addr, cur);
      chk("bp_req_valid", 64'(req), 64'(1'b1));
      chk("bp_addr_stable", 64'(addr), 64'(BASE));
      chk("bp_bubble", 64'(cur[31:0]), 64'(NOP));
    end
    d0 = delivered;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, req, addr, cur);
    chk("bp_resume", 64'((delivered - d0) >= 2), 64'(1'b1));

    // Redirect while requests are in flight: old responses must be dropped
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, req, addr, cur);
    step(1'b0, 1'b1, 32'h2000, 1'b1, 1'b1, req, addr, cur);
    chk("redir_req_blocked", 64'(req), 64'(1'b0));
    chk("redir_if_id", cur, {32'h2000, NOP});
    d0 = delivered;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, req, addr, cur);
    chk("redir_resume", 64'((delivered - d0) >= 2), 64'(1'b1));

    // Redirect coinciding with a response and a decode stall; low pc bits ignored
    do_reset();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, req, addr, cur);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, req, addr, cur);
    step(1'b1, 1'b1, 32'h3003, 1'b1, 1'b0, req, addr, cur);
    chk("redir_stall_if_id", cur, {32'h3000, NOP});
`ifdef FETCH_PREFETCH_BUF_EN
    chk("redir_stall_discard", 64'(dut.discard), 64'(2'd1));
`else
    chk("redir_stall_discard", 64'(dut.discard), 64'(2'd0));
`endif
    d0 = delivered;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, req, addr, cur);
    chk("redir_stall_resume", 64'((delivered - d0) >= 2), 64'(1'b1));

    // PC wrap through the top of the address space
    saw_zero = 1'b0;
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, req, addr, cur);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, req, addr, cur);
    chk("wrap_reaches_pc0", 64'(saw_zero), 64'(1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
